crossbar_scheduler: RTL

Packet-level scheduler that shares the outputs of a generic crossbar among its input ports. Each input presents a valid/ready stream tagged with a destination output index. Each output runs an independent round-robin arbiter that locks one input for a whole packet, delimited by `last`. The block drives the crossbar select configuration and gates the handshakes; data passes straight through from the winning input to its output.

---
 rtl/crossbar_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/crossbar_scheduler.sv
// Packet-level crossbar scheduler: one round-robin arbiter per output,
// locking an input for a whole packet and steering its stream through.
module crossbar_scheduler #(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_OUTPUTS = 2,
    parameter int WIDTH       = 8,
    localparam int DW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    localparam int SW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_INPUTS-1:0]        io_in_valid,
    input  logic [NUM_INPUTS*DW-1:0]     io_in_dest,
    input  logic [NUM_INPUTS-1:0]        io_in_last,
    input  logic [NUM_INPUTS*WIDTH-1:0]  io_in_data,
    output logic [NUM_INPUTS-1:0]        io_in_ready,
    output logic [NUM_OUTPUTS-1:0]       io_out_valid,
    output logic [NUM_OUTPUTS*WIDTH-1:0] io_out_data,
    output logic [NUM_OUTPUTS-1:0]       io_out_last,
    input  logic [NUM_OUTPUTS-1:0]       io_out_ready,
    output logic [NUM_OUTPUTS*SW-1:0]    io_select,
    output logic [NUM_OUTPUTS-1:0]       io_busy
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e          state_q [NUM_OUTPUTS];
    state_e          state_d [NUM_OUTPUTS];
    logic [SW-1:0]   owner_q [NUM_OUTPUTS];
    logic [SW-1:0]   owner_d [NUM_OUTPUTS];
    logic [SW-1:0]   rr_q    [NUM_OUTPUTS];
    logic [SW-1:0]   rr_d    [NUM_OUTPUTS];

    always_comb begin
        int   o;
        int   c;
        logic found;
        o            = 0;
        c            = 0;
        found        = 1'b0;
        io_in_ready  = '0;
        io_out_valid = '0;
        io_out_data  = '0;
        io_out_last  = '0;
        io_select    = '0;
        io_busy      = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            rr_d[j]    = rr_q[j];
            o          = int'(owner_q[j]);
            // Data/last follow the owner even when idle; valid qualifies them.
            io_select[j*SW +: SW]        = owner_q[j];
            io_out_data[j*WIDTH +: WIDTH] = io_in_data[o*WIDTH +: WIDTH];
            io_out_last[j]               = io_in_last[o];
            if (state_q[j] == S_LOCKED) begin
                io_busy[j]      = 1'b1;
                io_out_valid[j] = io_in_valid[o];
                if (io_out_ready[j]) begin
                    io_in_ready[o] = 1'b1;
                end
                if (io_in_valid[o] && io_out_ready[j] && io_in_last[o]) begin
                    state_d[j] = S_IDLE;
                    rr_d[j]    = owner_q[j];
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NUM_INPUTS; k++) begin
                    c = (int'(rr_q[j]) + k) % NUM_INPUTS;
                    if (!found && io_in_valid[c] &&
                        io_in_dest[c*DW +: DW] == DW'(j)) begin
                        found      = 1'b1;
                        owner_d[j] = SW'(c);
                        state_d[j] = S_LOCKED;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                state_q[j] <= S_IDLE;
                owner_q[j] <= '0;
                rr_q[j]    <= SW'(NUM_INPUTS - 1);
            end
        end else begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                rr_q[j]    <= rr_d[j];
            end
        end
    end

endmodule
